// File: rtl/char_phys_ctrl_pkg.sv
// Shared types and constants for the character controller: FSM states,
// game-state encodings and the video geometry.
package char_phys_ctrl_pkg;

  localparam int HOR_PIXELS = 1024;
  localparam int VER_PIXELS = 768;

  localparam logic [1:0] GA_MENU = 2'd0;
  localparam logic [1:0] GA_PLAY = 2'd1;
  localparam logic [1:0] GA_OVER = 2'd2;

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    AIR    = 2'd1,
    DEAD   = 2'd2
  } char_state_t;

endpackage

// File: rtl/char_phys_ctrl_if.sv
// Control inputs and sprite/health outputs between the input decoder,
// the character controller and the renderer/collision logic.
interface char_phys_ctrl_if;
  logic               stepleft;
  logic               stepright;
  logic               stepjump;
  logic               on_ground;
  logic [1:0]         game_active;
  logic               hit;
  logic [3:0]         hit_dmg;
  logic [11:0]        pos_x;
  logic [11:0]        pos_y;
  logic signed [7:0]  vel_y;
  logic [11:0]        ground_lvl;
  logic [3:0]         char_hp;
  logic               flip_h;
  logic               alive;
  logic               invuln;
  logic               frame_tick;

  modport master (
    output stepleft, stepright, stepjump, on_ground, game_active, hit, hit_dmg,
    input  pos_x, pos_y, vel_y, ground_lvl, char_hp, flip_h, alive, invuln, frame_tick
  );

  modport slave (
    input  stepleft, stepright, stepjump, on_ground, game_active, hit, hit_dmg,
    output pos_x, pos_y, vel_y, ground_lvl, char_hp, flip_h, alive, invuln, frame_tick
  );
endinterface

// File: rtl/char_phys_ctrl_frame_tick_gen.sv
// Frame-rate strobe: one-cycle pulse every CLK_HZ/FRAME_HZ clocks, asserted
// in the cycle following the divider's terminal count.
module frame_tick_gen #(
  parameter int CLK_HZ   = 65_000_000,
  parameter int FRAME_HZ = 60
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int DIV = CLK_HZ / FRAME_HZ;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (cnt == TERM);
      cnt  <= (cnt == TERM) ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/char_phys_ctrl.sv
// Player/NPC controller: frame-rate velocity/gravity motion, facing,
// health with invulnerability frames, and a DEAD state left only via MENU.
module char_phys_ctrl
  import char_phys_ctrl_pkg::*;
#(
  parameter int CLK_HZ    = 65_000_000,
  parameter int FRAME_HZ  = 60,
  parameter int CHAR_W    = 19,
  parameter int CHAR_H    = 27,
  parameter int SPAWN_X   = HOR_PIXELS / 5,
  parameter int GROUND_Y  = VER_PIXELS - 52 - CHAR_H,
  parameter int MOVE_STEP = 5,
  parameter int JUMP_V0   = 12,
  parameter int GRAVITY   = 1,
  parameter int VMAX_FALL = 10,
  parameter int HP_MAX    = 10,
  parameter int IFRAMES   = 60
) (
  input  logic             clk,
  input  logic             rst_n,
  char_phys_ctrl_if.slave  bus
);

  localparam logic [11:0]        SPAWN_X_L  = 12'(SPAWN_X);
  localparam logic [11:0]        GROUND_Y_L = 12'(GROUND_Y);
  localparam logic [11:0]        STEP_L     = 12'(MOVE_STEP);
  localparam logic [11:0]        LEFT_LIM   = 12'(CHAR_W + MOVE_STEP);
  localparam logic [11:0]        RIGHT_LIM  = 12'(HOR_PIXELS - CHAR_W - MOVE_STEP);
  localparam logic signed [7:0]  JUMP_V     = 8'(-JUMP_V0);
  localparam logic signed [7:0]  VMAX8      = 8'(VMAX_FALL);
  localparam logic signed [8:0]  VMAX9      = 9'(VMAX_FALL);
  localparam logic signed [8:0]  GRAV9      = 9'(GRAVITY);
  localparam logic signed [12:0] GROUND_S   = 13'(GROUND_Y);
  localparam logic [3:0]         HP_INIT    = 4'(HP_MAX);
  localparam int                 ICW        = $clog2(IFRAMES + 1);
  localparam logic [ICW-1:0]     IFR_L      = ICW'(IFRAMES);

  function automatic logic [3:0] hp_sat_sub(input logic [3:0] hp, input logic [3:0] dmg);
    return (dmg >= hp) ? 4'd0 : hp - dmg;
  endfunction

  // Gravity step clamped to terminal fall speed.
  function automatic logic signed [7:0] fall_speed(input logic signed [7:0] v);
    logic signed [8:0] inc;
    inc = $signed({v[7], v}) + GRAV9;
    return (inc > VMAX9) ? VMAX8 : $signed(inc[7:0]);
  endfunction

  char_state_t       state_q, state_d;
  logic [11:0]       pos_x_q, pos_x_d;
  logic [11:0]       pos_y_q, pos_y_d;
  logic signed [7:0] vel_q, vel_d;
  logic [3:0]        hp_q, hp_d;
  logic              flip_q, flip_d;
  logic              alive_q, alive_d;
  logic              inv_q, inv_d;
  logic [ICW-1:0]    icnt_q, icnt_d;
  logic              tick;
  logic signed [12:0] sum;
  logic signed [7:0]  vnew;

  frame_tick_gen #(
    .CLK_HZ   (CLK_HZ),
    .FRAME_HZ (FRAME_HZ)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign sum  = $signed({1'b0, pos_y_q}) + $signed({{5{vel_q[7]}}, vel_q});
  assign vnew = fall_speed(vel_q);

  always_comb begin
    state_d = state_q;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    vel_d   = vel_q;
    hp_d    = hp_q;
    flip_d  = flip_q;
    icnt_d  = icnt_q;
    case (bus.game_active)
      GA_MENU: begin
        state_d = GROUND;
        pos_x_d = SPAWN_X_L;
        pos_y_d = GROUND_Y_L;
        vel_d   = '0;
        hp_d    = HP_INIT;
        icnt_d  = '0;
      end
      GA_PLAY: begin
        if (bus.stepleft)       flip_d = 1'b1;
        else if (bus.stepright) flip_d = 1'b0;
        if (tick && icnt_q != '0) icnt_d = icnt_q - ICW'(1);
        if (tick && state_q != DEAD) begin
          if (bus.stepleft) begin
            if (pos_x_q > LEFT_LIM) pos_x_d = pos_x_q - STEP_L;
          end else if (bus.stepright && pos_x_q < RIGHT_LIM) begin
            pos_x_d = pos_x_q + STEP_L;
          end
          case (state_q)
            GROUND: begin
              if (bus.stepjump && bus.on_ground) begin
                vel_d   = JUMP_V;
                state_d = AIR;
              end else if (!bus.on_ground && pos_y_q < GROUND_Y_L) begin
                vel_d   = '0;
                state_d = AIR;
              end
            end
            AIR: begin
              if (sum[12]) begin
                pos_y_d = '0;
                vel_d   = '0;
              end else if (!vnew[7] && (bus.on_ground || sum >= GROUND_S)) begin
                pos_y_d = (sum > GROUND_S) ? GROUND_Y_L : sum[11:0];
                vel_d   = '0;
                state_d = GROUND;
              end else begin
                pos_y_d = sum[11:0];
                vel_d   = vnew;
              end
            end
            default: ;
          endcase
        end
        // Damage overrides the motion state but keeps the motion result.
        if (state_q != DEAD && bus.hit && icnt_q == '0) begin
          hp_d   = hp_sat_sub(hp_q, bus.hit_dmg);
          icnt_d = IFR_L;
          if (hp_d == 4'd0) state_d = DEAD;
        end
      end
      default: ;
    endcase
    alive_d = (state_d != DEAD);
    inv_d   = (icnt_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= GROUND;
      pos_x_q <= SPAWN_X_L;
      pos_y_q <= GROUND_Y_L;
      vel_q   <= '0;
      hp_q    <= HP_INIT;
      flip_q  <= 1'b0;
      alive_q <= 1'b1;
      inv_q   <= 1'b0;
      icnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      vel_q   <= vel_d;
      hp_q    <= hp_d;
      flip_q  <= flip_d;
      alive_q <= alive_d;
      inv_q   <= inv_d;
      icnt_q  <= icnt_d;
    end
  end

  assign bus.pos_x      = pos_x_q;
  assign bus.pos_y      = pos_y_q;
  assign bus.vel_y      = vel_q;
  assign bus.ground_lvl = GROUND_Y_L;
  assign bus.char_hp    = hp_q;
  assign bus.flip_h     = flip_q;
  assign bus.alive      = alive_q;
  assign bus.invuln     = inv_q;
  assign bus.frame_tick = tick;

endmodule

// File: tb/tb_char_phys_ctrl.sv
// Scoreboard bench for char_phys_ctrl at 10 clocks per frame.
module tb_char_phys_ctrl;
  import char_phys_ctrl_pkg::*;

  localparam int DIV   = 10;
  localparam int SPX   = 204;
  localparam int GNDY  = 689;

  typedef struct {
    int px;
    int py;
    int vy;
    int hp;
    int alive;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t sb[$];

  int m_px, m_py, m_vy, m_hp;
  bit m_air, m_dead;

  char_phys_ctrl_if bus();

  char_phys_ctrl #(.CLK_HZ(600), .FRAME_HZ(60)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_px = SPX; m_py = GNDY; m_vy = 0; m_hp = 10; m_air = 0; m_dead = 0;
  endtask

  task automatic model_frame(input bit l, input bit r, input bit j, input bit og);
    int sum, nv;
    if (m_dead) return;
    if (l) begin
      if (m_px > 24) m_px -= 5;
    end else if (r) begin
      if (m_px < 1000) m_px += 5;
    end
    if (!m_air) begin
      if (j && og) begin m_vy = -12; m_air = 1; end
      else if (!og && m_py < GNDY) begin m_vy = 0; m_air = 1; end
    end else begin
      sum = m_py + m_vy;
      nv  = (m_vy + 1 > 10) ? 10 : m_vy + 1;
      if (sum < 0) begin m_py = 0; m_vy = 0; end
      else if (nv >= 0 && (og || sum >= GNDY)) begin
        m_py = (sum > GNDY) ? GNDY : sum; m_vy = 0; m_air = 0;
      end else begin m_py = sum; m_vy = nv; end
    end
  endtask

  function automatic exp_t model_snap();
    exp_t e;
    e.px = m_px; e.py = m_py; e.vy = m_vy; e.hp = m_hp; e.alive = m_dead ? 0 : 1;
    return e;
  endfunction

  task automatic wait_tick();
    bit seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (bus.frame_tick) seen = 1;
    end
    n_cmp++;
    if (!seen) begin
      n_fail++;
      $display("FAIL frame_tick_timeout: none within 30 cycles, required one per %0d", DIV);
    end
  endtask

  task automatic align();
    wait_tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    int got[9], expv[9];
    string nm[9];
    int k;
    bus.stepleft = 0; bus.stepright = 0; bus.stepjump = 0; bus.on_ground = 1;
    bus.game_active = GA_PLAY; bus.hit = 0; bus.hit_dmg = 0;
    rst_n = 0;
    repeat (3) @(negedge clk);
    nm = '{"rst_pos_x","rst_pos_y","rst_vel_y","rst_hp","rst_flip","rst_alive","rst_invuln","rst_tick","ground_lvl"};
    got = '{int'(bus.pos_x), int'(bus.pos_y), int'(bus.vel_y), int'(bus.char_hp), int'(bus.flip_h),
            int'(bus.alive), int'(bus.invuln), int'(bus.frame_tick), int'(bus.ground_lvl)};
    expv = '{SPX, GNDY, 0, 10, 0, 1, 0, 0, GNDY};
    for (int i = 0; i < 9; i++) begin
      n_cmp++;
      if (got[i] !== expv[i]) begin
        n_fail++;
        $display("FAIL %s: got %0d, required %0d", nm[i], got[i], expv[i]);
      end
    end
    rst_n = 1;
    for (int p = 0; p < 2; p++) begin
      k = 0;
      for (int i = 1; i <= 30 && k == 0; i++) begin
        @(negedge clk);
        if (bus.frame_tick) k = i;
      end
      n_cmp++;
      if (k != DIV) begin
        n_fail++;
        $display("FAIL tick_period_%0d: got %0d cycles, required %0d", p, k, DIV);
      end
    end
    @(negedge clk);
    model_reset();
    for (int f = 0; f < 2; f++) begin
      model_frame(0, 0, 0, 1);
      sb.push_back(model_snap());
      align();
      begin
        exp_t e = sb.pop_front();
        n_cmp++;
        if (int'(bus.pos_x) !== e.px || int'(bus.pos_y) !== e.py) begin
          n_fail++;
          $display("FAIL idle_pos f%0d: got %0d,%0d required %0d,%0d", f, bus.pos_x, bus.pos_y, e.px, e.py);
        end
      end
    end
  endtask

  task automatic test_move();
    bus.stepright = 1;
    @(negedge clk);
    n_cmp++;
    if (bus.flip_h !== 1'b0) begin
      n_fail++; $display("FAIL flip_right: got %0b, required 0", bus.flip_h);
    end
    for (int f = 0; f < 4; f++) begin
      if (f == 3) begin
        bus.stepleft = 1;
        @(negedge clk);
        n_cmp++;
        if (bus.flip_h !== 1'b1) begin
          n_fail++; $display("FAIL flip_left: got %0b, required 1", bus.flip_h);
        end
      end
      model_frame(bus.stepleft, bus.stepright, 0, 1);
      sb.push_back(model_snap());
      align();
      begin
        exp_t e = sb.pop_front();
        n_cmp++;
        if (int'(bus.pos_x) !== e.px) begin
          n_fail++; $display("FAIL move_x f%0d: got %0d, required %0d", f, bus.pos_x, e.px);
        end
      end
    end
    n_cmp++;
    if (bus.pos_x !== 12'd214) begin
      n_fail++; $display("FAIL both_keys_left: got %0d, required 214", bus.pos_x);
    end
    bus.stepleft = 0; bus.stepright = 0;
  endtask

  task automatic test_jump();
    int min_py = 4096;
    bus.stepjump = 1; bus.on_ground = 1;
    model_frame(0, 0, 1, 1);
    sb.push_back(model_snap());
    align();
    bus.stepjump = 0; bus.on_ground = 0;
    n_cmp++;
    if (bus.vel_y !== -8'sd12 || bus.pos_y !== 12'd689) begin
      n_fail++; $display("FAIL jump_start: got vel %0d pos %0d, required -12 689", bus.vel_y, bus.pos_y);
    end
    void'(sb.pop_front());
    for (int f = 1; f <= 40 && m_air; f++) begin
      model_frame(0, 0, 0, 0);
      sb.push_back(model_snap());
      align();
      begin
        exp_t e = sb.pop_front();
        n_cmp++;
        if (int'(bus.pos_y) !== e.py || int'(bus.vel_y) !== e.vy) begin
          n_fail++;
          $display("FAIL air_frame %0d: got y %0d v %0d, required y %0d v %0d", f, bus.pos_y, bus.vel_y, e.py, e.vy);
        end
      end
      if (int'(bus.pos_y) < min_py) min_py = int'(bus.pos_y);
    end
    n_cmp++;
    if (min_py != 611) begin
      n_fail++; $display("FAIL jump_apex: got %0d, required 611", min_py);
    end
    n_cmp++;
    if (bus.pos_y !== 12'd689 || bus.vel_y !== 8'sd0) begin
      n_fail++; $display("FAIL landing: got y %0d v %0d, required 689 0", bus.pos_y, bus.vel_y);
    end
    bus.on_ground = 1;
  endtask

  task automatic test_damage();
    int frames = 0;
    align();
    bus.hit = 1; bus.hit_dmg = 4'd3;
    m_hp = 7;
    sb.push_back(model_snap());
    @(negedge clk);
    bus.hit = 0;
    begin
      exp_t e = sb.pop_front();
      n_cmp++;
      if (int'(bus.char_hp) !== e.hp || bus.invuln !== 1'b1) begin
        n_fail++; $display("FAIL hit1: got hp %0d inv %0b, required %0d 1", bus.char_hp, bus.invuln, e.hp);
      end
    end
    for (int f = 0; f < 100; f++) begin
      align();
      frames++;
      if (frames == 5) begin
        bus.hit = 1; bus.hit_dmg = 4'd3;
        sb.push_back(model_snap());
        @(negedge clk);
        bus.hit = 0;
        begin
          exp_t e = sb.pop_front();
          n_cmp++;
          if (int'(bus.char_hp) !== e.hp) begin
            n_fail++; $display("FAIL hit_during_invuln: got %0d, required %0d", bus.char_hp, e.hp);
          end
        end
      end
      if (!bus.invuln) break;
    end
    n_cmp++;
    if (frames != 60) begin
      n_fail++; $display("FAIL invuln_frames: got %0d, required 60", frames);
    end
    bus.hit = 1; bus.hit_dmg = 4'd3;
    m_hp = 4;
    sb.push_back(model_snap());
    @(negedge clk);
    bus.hit = 0;
    begin
      exp_t e = sb.pop_front();
      n_cmp++;
      if (int'(bus.char_hp) !== e.hp || bus.invuln !== 1'b1) begin
        n_fail++; $display("FAIL hit3: got hp %0d inv %0b, required %0d 1", bus.char_hp, bus.invuln, e.hp);
      end
    end
  endtask

  task automatic test_kill();
    bus.game_active = GA_MENU;
    repeat (2) @(negedge clk);
    model_reset();
    n_cmp++;
    if (bus.pos_x !== 12'd204 || bus.char_hp !== 4'd10 || bus.invuln !== 1'b0 || bus.alive !== 1'b1) begin
      n_fail++; $display("FAIL menu_respawn1: got x %0d hp %0d inv %0b", bus.pos_x, bus.char_hp, bus.invuln);
    end
    bus.game_active = GA_PLAY;
    align();
    bus.stepjump = 1;
    model_frame(0, 0, 1, 1);
    align();
    bus.stepjump = 0; bus.on_ground = 0;
    for (int f = 0; f < 3; f++) begin
      model_frame(0, 0, 0, 0);
      align();
    end
    // Next hit lands on the same edge as the frame update.
    model_frame(0, 0, 0, 0);
    m_hp = 0; m_dead = 1;
    sb.push_back(model_snap());
    wait_tick();
    bus.hit = 1; bus.hit_dmg = 4'd15;
    @(negedge clk);
    bus.hit = 0;
    begin
      exp_t e = sb.pop_front();
      n_cmp++;
      if (int'(bus.pos_y) !== e.py || int'(bus.char_hp) !== e.hp || int'(bus.alive) !== e.alive) begin
        n_fail++;
        $display("FAIL kill: got y %0d hp %0d alive %0b, required %0d %0d %0d", bus.pos_y, bus.char_hp, bus.alive, e.py, e.hp, e.alive);
      end
    end
    for (int f = 0; f < 3; f++) begin
      model_frame(0, 0, 0, 0);
      sb.push_back(model_snap());
      align();
      begin
        exp_t e = sb.pop_front();
        n_cmp++;
        if (int'(bus.pos_y) !== e.py || int'(bus.alive) !== e.alive) begin
          n_fail++; $display("FAIL dead_frozen f%0d: got y %0d alive %0b, required %0d %0d", f, bus.pos_y, bus.alive, e.py, e.alive);
        end
      end
    end
    bus.game_active = GA_MENU;
    repeat (2) @(negedge clk);
    model_reset();
    n_cmp++;
    if (bus.pos_x !== 12'd204 || bus.pos_y !== 12'd689 || bus.char_hp !== 4'd10 || bus.alive !== 1'b1 || bus.vel_y !== 8'sd0) begin
      n_fail++; $display("FAIL menu_respawn2: got x %0d y %0d hp %0d alive %0b", bus.pos_x, bus.pos_y, bus.char_hp, bus.alive);
    end
    bus.on_ground = 1;
    bus.game_active = GA_PLAY;
  endtask

  task automatic test_over();
    align();
    bus.game_active = GA_OVER;
    bus.stepright = 1; bus.hit = 1; bus.hit_dmg = 4'd5;
    @(negedge clk);
    bus.hit = 0;
    align();
    n_cmp++;
    if (bus.pos_x !== 12'd204 || bus.char_hp !== 4'd10 || bus.invuln !== 1'b0) begin
      n_fail++; $display("FAIL over_frozen: got x %0d hp %0d inv %0b, required 204 10 0", bus.pos_x, bus.char_hp, bus.invuln);
    end
    bus.stepright = 0;
    bus.game_active = GA_PLAY;
  endtask

  task automatic test_async_reset();
    int k = 0;
    align();
    bus.stepjump = 1;
    align();
    bus.stepjump = 0; bus.on_ground = 0;
    align();
    align();
    bus.hit = 1; bus.hit_dmg = 4'd2;
    @(negedge clk);
    bus.hit = 0;
    n_cmp++;
    if (bus.char_hp !== 4'd8 || bus.invuln !== 1'b1 || bus.vel_y === 8'sd0) begin
      n_fail++; $display("FAIL pre_reset: got hp %0d inv %0b vel %0d", bus.char_hp, bus.invuln, bus.vel_y);
    end
    #2 rst_n = 0;
    #1;
    n_cmp++;
    if (bus.pos_x !== 12'd204 || bus.pos_y !== 12'd689 || bus.vel_y !== 8'sd0 || bus.char_hp !== 4'd10 ||
        bus.flip_h !== 1'b0 || bus.alive !== 1'b1 || bus.invuln !== 1'b0 || bus.frame_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got x %0d y %0d v %0d hp %0d inv %0b", bus.pos_x, bus.pos_y, bus.vel_y, bus.char_hp, bus.invuln);
    end
    bus.on_ground = 1;
    @(negedge clk);
    rst_n = 1;
    for (int i = 1; i <= 30 && k == 0; i++) begin
      @(negedge clk);
      if (bus.frame_tick) k = i;
    end
    n_cmp++;
    if (k != DIV) begin
      n_fail++; $display("FAIL tick_after_reset: got %0d cycles, required %0d", k, DIV);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_move();
    test_jump();
    test_damage();
    test_kill();
    test_over();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
